// File: rtl/regbank_mp.sv
// Parametrised multi-port register bank: two byte-enabled write ports (port 1 wins),
// optional hardwired zero register, write-to-read bypass and optional registered reads.
module regbank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write0,
  input  logic [ADDR_W-1:0]        dr0,
  input  logic [DATA_W-1:0]        wrData0,
  input  logic [DATA_W/8-1:0]      be0,
  input  logic                     write1,
  input  logic [ADDR_W-1:0]        dr1,
  input  logic [DATA_W-1:0]        wrData1,
  input  logic [DATA_W/8-1:0]      be1,
  input  logic [NRD*ADDR_W-1:0]    sr,
  output logic [NRD*DATA_W-1:0]    rdData
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]     regs_q [DEPTH];
  logic [DATA_W-1:0]     regs_d [DEPTH];
  logic [NRD*DATA_W-1:0] rd_d;

  // regs_d is the post-edge value of every register; it doubles as the bypass source.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      for (int b = 0; b < NBYTES; b++) begin
        if (write1 && dr1 == ADDR_W'(r) && be1[b]) begin
          regs_d[r][b*8 +: 8] = wrData1[b*8 +: 8];
        end else if (write0 && dr0 == ADDR_W'(r) && be0[b]) begin
          regs_d[r][b*8 +: 8] = wrData0[b*8 +: 8];
        end
      end
      if (ZERO_REG != 0 && r == 0) begin
        regs_d[r] = '0;
      end
    end
  end

  // NOTE: the array is reset on purpose so every register reads 0 after reset; this
  // keeps it in flops rather than a RAM macro, which suits a small operand register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] addr;
    rd_d = '0;
    addr = '0;
    for (int k = 0; k < NRD; k++) begin
      addr = sr[k*ADDR_W +: ADDR_W];
      if (ZERO_REG != 0 && addr == '0) begin
        rd_d[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS != 0) begin
        rd_d[k*DATA_W +: DATA_W] = regs_d[addr];
      end else begin
        rd_d[k*DATA_W +: DATA_W] = regs_q[addr];
      end
    end
  end

  if (READ_LAT != 0) begin : g_rd_reg
    logic [NRD*DATA_W-1:0] rd_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rdData = rd_q;
  end else begin : g_rd_comb
    // Registers already read 0 in reset; the gate only hides bypassed write data.
    assign rdData = reset ? rd_d : '0;
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: three instances (defaults, no bypass, registered read)
// share the stimulus; expected read values are queued and checked by a negedge monitor.
module tb_regbank_mp;

  logic        clk;
  logic        reset;
  logic        write0, write1;
  logic [4:0]  dr0, dr1;
  logic [31:0] wrData0, wrData1;
  logic [3:0]  be0, be1;
  logic [9:0]  sr;
  logic [63:0] rd_def, rd_nb, rd_lat;

  typedef struct {
    string       name;
    int          dut;
    int          port;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  regbank_mp u_def (
    .clk(clk), .reset(reset),
    .write0(write0), .dr0(dr0), .wrData0(wrData0), .be0(be0),
    .write1(write1), .dr1(dr1), .wrData1(wrData1), .be1(be1),
    .sr(sr), .rdData(rd_def)
  );

  regbank_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset),
    .write0(write0), .dr0(dr0), .wrData0(wrData0), .be0(be0),
    .write1(write1), .dr1(dr1), .wrData1(wrData1), .be1(be1),
    .sr(sr), .rdData(rd_nb)
  );

  regbank_mp #(.READ_LAT(1)) u_lat (
    .clk(clk), .reset(reset),
    .write0(write0), .dr0(dr0), .wrData0(wrData0), .be0(be0),
    .write1(write1), .dr1(dr1), .wrData1(wrData1), .be1(be1),
    .sr(sr), .rdData(rd_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dut_rd(input int dut, input int port);
    case (dut)
      0:       return rd_def[port*32 +: 32];
      1:       return rd_nb[port*32 +: 32];
      default: return rd_lat[port*32 +: 32];
    endcase
  endfunction

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  initial begin
    chk_t        c;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c   = sb.pop_front();
        got = dut_rd(c.dut, c.port);
        chk_cnt++;
        if (got === c.exp) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: dut%0d port%0d got %h expected %h", c.name, c.dut, c.port, got, c.exp);
        end
      end
    end
  end

  task automatic expect_rd(input string name, input int dut, input int port, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.dut  = dut;
    c.port = port;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write0 = 1'b0; dr0 = '0; wrData0 = '0; be0 = '0;
    write1 = 1'b0; dr1 = '0; wrData1 = '0; be1 = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    write0 = 1'b1; dr0 = a; wrData0 = d; be0 = b;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    write1 = 1'b1; dr1 = a; wrData1 = d; be1 = b;
  endtask

  task automatic set_sr(input logic [4:0] a0, input logic [4:0] a1);
    sr = {a1, a0};
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_sr(5'd5, 5'd0);

    // Reset held: a write is ignored and not bypassed.
    cyc();
    wr0(5'd5, 32'hCAFEF00D, 4'hF);
    expect_rd("reset_rd_def", 0, 0, 32'h0);
    expect_rd("reset_rd_lat", 2, 0, 32'h0);
    cyc();
    reset = 1'b1;
    idle();
    expect_rd("post_reset_rd", 0, 0, 32'h0);
    expect_rd("post_reset_nb", 1, 0, 32'h0);

    // Fill reg[k] = 10*k, then read back in pairs.
    for (int k = 0; k < 32; k++) begin
      cyc();
      wr0(5'(k), 32'(10 * k), 4'hF);
    end
    cyc();
    idle();
    for (int k = 0; k < 32; k += 2) begin
      set_sr(5'(k), 5'(k + 1));
      expect_rd("fill_even", 0, 0, (k == 0) ? 32'h0 : 32'(10 * k));
      expect_rd("fill_odd", 0, 1, 32'(10 * (k + 1)));
      cyc();
    end

    // Byte enables on reg[5].
    wr0(5'd5, 32'h11223344, 4'hF);
    cyc();
    wr0(5'd5, 32'hAABBCCDD, 4'b0101);
    set_sr(5'd5, 5'd1);
    expect_rd("be_bypass", 0, 0, 32'h11BB33DD);
    expect_rd("be_nobypass_pre", 1, 0, 32'h11223344);
    cyc();
    wr0(5'd5, 32'hFFFFFFFF, 4'b0000);
    expect_rd("be_zero_bypass", 0, 0, 32'h11BB33DD);
    expect_rd("be_zero_nb", 1, 0, 32'h11BB33DD);
    cyc();
    idle();
    expect_rd("be_zero_after", 0, 0, 32'h11BB33DD);

    // Dual write: same address merges per byte, different addresses are independent.
    cyc();
    wr0(5'd7, 32'h0000FFFF, 4'hF);
    wr1(5'd7, 32'h12345678, 4'b1100);
    set_sr(5'd7, 5'd7);
    expect_rd("dual_same_bypass", 0, 0, 32'h1234FFFF);
    expect_rd("dual_same_nb_pre", 1, 1, 32'd70);
    cyc();
    wr0(5'd3, 32'hA5A5A5A5, 4'hF);
    wr1(5'd4, 32'h5A5A5A5A, 4'hF);
    set_sr(5'd3, 5'd4);
    expect_rd("dual_diff_p0", 0, 0, 32'hA5A5A5A5);
    expect_rd("dual_diff_p1", 0, 1, 32'h5A5A5A5A);
    expect_rd("dual_diff_nb_p0", 1, 0, 32'd30);
    expect_rd("dual_diff_nb_p1", 1, 1, 32'd40);
    cyc();
    idle();
    expect_rd("dual_diff_nb_post0", 1, 0, 32'hA5A5A5A5);
    expect_rd("dual_diff_nb_post1", 1, 1, 32'h5A5A5A5A);
    cyc();
    wr0(5'd0, 32'hDEADBEEF, 4'hF);
    wr1(5'd0, 32'hBEEFDEAD, 4'hF);
    set_sr(5'd0, 5'd7);
    expect_rd("zero_bypass", 0, 0, 32'h0);
    expect_rd("dual_same_post", 1, 1, 32'h1234FFFF);
    cyc();
    idle();
    expect_rd("zero_after", 0, 0, 32'h0);
    expect_rd("zero_after_nb", 1, 0, 32'h0);

    // Bypass versus pre-edge read on reg[9].
    cyc();
    wr0(5'd9, 32'd100, 4'hF);
    cyc();
    wr0(5'd9, 32'd250, 4'hF);
    set_sr(5'd9, 5'd4);
    expect_rd("bypass_on", 0, 0, 32'd250);
    expect_rd("bypass_off_pre", 1, 0, 32'd100);
    cyc();
    idle();
    expect_rd("bypass_off_post", 1, 0, 32'd250);
    expect_rd("lat_bypass_reg", 2, 0, 32'd250);

    // Registered read: one cycle latency, then asynchronous clear.
    cyc();
    set_sr(5'd9, 5'd12);
    expect_rd("lat_old_value", 2, 1, 32'h5A5A5A5A);
    expect_rd("comb_new_value", 0, 1, 32'd120);
    cyc();
    expect_rd("lat_one_edge", 2, 1, 32'd120);
    cyc();
    #2;
    reset = 1'b0;
    expect_rd("lat_async_clr1", 2, 1, 32'h0);
    expect_rd("lat_async_clr0", 2, 0, 32'h0);
    expect_rd("comb_async_clr0", 0, 0, 32'h0);
    expect_rd("comb_async_clr1", 0, 1, 32'h0);

    // Release, refill reg[1..10], drop reset between edges, then resume.
    cyc();
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wr0(5'(k), 32'(10 * k), 4'hF);
      cyc();
    end
    idle();
    set_sr(5'd1, 5'd10);
    expect_rd("refill_1", 0, 0, 32'd10);
    expect_rd("refill_10", 0, 1, 32'd100);
    cyc();
    #2;
    reset = 1'b0;
    expect_rd("midfill_clr_1", 0, 0, 32'h0);
    expect_rd("midfill_clr_10", 0, 1, 32'h0);
    expect_rd("midfill_clr_nb", 1, 1, 32'h0);
    cyc();
    wr0(5'd6, 32'd66, 4'hF);
    set_sr(5'd6, 5'd5);
    expect_rd("rst_write_hidden", 0, 0, 32'h0);
    expect_rd("rst_reg5", 0, 1, 32'h0);
    cyc();
    reset = 1'b1;
    wr0(5'd2, 32'd20, 4'hF);
    set_sr(5'd2, 5'd3);
    expect_rd("resume_bypass", 0, 0, 32'd20);
    expect_rd("resume_reg3", 0, 1, 32'h0);
    cyc();
    idle();
    expect_rd("resume_reg2", 0, 0, 32'd20);
    expect_rd("resume_reg2_nb", 1, 0, 32'd20);
    cyc();
    set_sr(5'd6, 5'd10);
    expect_rd("resume_reg6", 0, 0, 32'h0);
    expect_rd("resume_reg10", 0, 1, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      cyc();
    end
    if (sb.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
Parametrised multi-port register bank, the successor to the current 32x32 two-read/one-write bank. Depth, width and read-port count are configurable. It adds a second write port with fixed priority, byte-enable writes, an optional hardwired-zero register 0, write-to-read bypass, and an optional registered read stage. It sits in the datapath between decode (register addresses) and execute/writeback (operands and results).

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; depth = 2**ADDR_W.
NRD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.
BYPASS, 1, 1 = a same-cycle write to the addressed register is forwarded to the read output.
READ_LAT, 0, 0 = combinational read; 1 = read data registered (one-cycle latency).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
write0  in  1  write enable, port 0.
dr0  in  ADDR_W  destination address, port 0.
wrData0  in  DATA_W  write data, port 0.
be0  in  DATA_W/8  byte enables, port 0 (bit i covers byte i).
write1  in  1  write enable, port 1.
dr1  in  ADDR_W  destination address, port 1.
wrData1  in  DATA_W  write data, port 1.
be1  in  DATA_W/8  byte enables, port 1.
sr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
rdData  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (reset=0, asynchronous): all registers clear to 0. With READ_LAT=1, the rdData output registers also clear to 0. With READ_LAT=0, rdData shows 0 for every address while reset is held. Writes are ignored while reset=0. Deasserting reset mid-sequence resumes normal operation at the next rising edge, with all registers 0.
- Write: on a rising edge with writeN=1, each byte i of reg[drN] with beN[i]=1 takes byte i of wrDataN. Bytes with beN[i]=0 are unchanged. writeN=1 with beN all zeros is a no-op.
- Dual write, same address: byte-wise merge. For each byte, port 1 wins if be1[i]=1, otherwise port 0 is used if be0[i]=1. Dual writes to different addresses are independent.
- ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0 regardless of bypass.
- Read, READ_LAT=0: rdData[k] = reg[sr[k]] combinationally.
- Read, READ_LAT=1: rdData[k] is registered at the rising edge from the same value; one cycle latency.
- BYPASS=1: if sr[k] matches an enabled write address in the current cycle, rdData[k] shows the post-merge value, meaning the value the register will hold after this edge. Enabled bytes come from the write data; disabled bytes come from the register. Priority is the same as for dual writes.
- BYPASS=0: reads return the pre-edge register contents.
- All NRD read ports are independent; any of them may read the same address.
- No illegal inputs. Out-of-range addresses cannot occur because depth = 2**ADDR_W.

Test Plan:
1. Defaults, reset pulse then fill: write reg[k]=10*k for k=0..31, one per cycle, be0=4'hF. Read pairs (k, k+1) -> reg[0]=0 (ZERO_REG), reg[k]=10*k for k>=1.
2. Byte enables: reg[5]=32'h11223344, then write 32'hAABBCCDD with be0=4'b0101 -> reg[5]=32'h11BB33DD. be0=0 with write0=1 -> unchanged.
3. Dual write, same cycle, dr0=dr1=7: wrData0=32'h0000FFFF with be0=4'hF, wrData1=32'h12345678 with be1=4'b1100 -> reg[7]=32'h1234FFFF. Also dr0=3, dr1=4 in the same cycle -> both written.
4. Bypass (READ_LAT=0, BYPASS=1): reg[9]=100, then write 250 to dr0=9 with sr[0]=9 -> rdData[0]=250 before the edge. Same test with BYPASS=0 -> rdData[0]=100 before the edge and 250 after.
5. READ_LAT=1: set sr[1]=12 with reg[12]=120 -> rdData[1]=120 exactly one edge later and still the old value in the cycle sr changes. Assert reset mid-run -> rdData=0 immediately, before any edge.
6. Asynchronous reset mid-fill: drop reset between edges after writing reg[1..10] -> all reads 0 immediately. Release reset and write reg[2]=20 -> reg[2]=20, all others 0.
